// File: rtl/aes_inv_ctrl.sv
// Control sequencer for the AES-128 decryption datapath.
// A synchronised rising edge of `start` loads the cipher key. The sequencer then
// runs 10 forward key-expansion cycles to reach round key 10. It then runs
// 11 inverse-cipher cycles while walking the key register back to round key 0.
module aes_inv_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       start_pos,
  output logic       start_pos_1d,
  output logic       key_load,
  output logic       key_fwd_update,
  output logic       key_inv_update,
  output logic       state_load,
  output logic       state_update,
  output logic       is_last_round,
  output logic [7:0] rcon,
  output logic       busy,
  output logic       done,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    RND  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                 state_q;
  logic [3:0]             kcnt_q;
  logic [3:0]             rcnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   valid_q;
  logic                   kexp_ok;
  logic                   rnd_ok;

  // Round constant indexed by round number 1..10. Any other index gives 0.
  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Synchronise the asynchronous start level and keep one history bit for edge detection.
  // NOTE: registers are written with <= so that every flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], start};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign start_pos = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Counters are only meaningful inside their defined ranges.
  // Any other decode is treated as illegal.
  assign kexp_ok = (state_q == KEXP) && (kcnt_q >= 4'd1) && (kcnt_q <= 4'd10);
  assign rnd_ok  = (state_q == RND)  && (rcnt_q <= 4'd10);

  // Sequencer state and counters. A new start edge restarts from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kcnt_q  <= 4'd0;
      rcnt_q  <= 4'd0;
    end else if (start_pos) begin
      state_q <= KEXP;
      kcnt_q  <= 4'd1;
      rcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          kcnt_q <= 4'd0;
          rcnt_q <= 4'd0;
        end
        KEXP: begin
          if (!kexp_ok) begin
            state_q <= IDLE;
            kcnt_q  <= 4'd0;
          end else if (kcnt_q == 4'd10) begin
            state_q <= RND;
            kcnt_q  <= 4'd0;
            rcnt_q  <= 4'd10;
          end else begin
            kcnt_q <= kcnt_q + 4'd1;
          end
        end
        RND: begin
          if (!rnd_ok) begin
            state_q <= IDLE;
            rcnt_q  <= 4'd0;
          end else if (rcnt_q == 4'd0) begin
            state_q <= FIN;
          end else begin
            rcnt_q <= rcnt_q - 4'd1;
          end
        end
        FIN: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          kcnt_q  <= 4'd0;
          rcnt_q  <= 4'd0;
        end
      endcase
    end
  end

  // Strobe and rcon decode from the current state. A start edge overrides the decode to a bare key load.
  // NOTE: every output gets a default before the case so that no path leaves one unassigned; that keeps this block latch-free.
  always_comb begin
    key_load       = 1'b0;
    key_fwd_update = 1'b0;
    key_inv_update = 1'b0;
    state_load     = 1'b0;
    state_update   = 1'b0;
    is_last_round  = 1'b0;
    done           = 1'b0;
    rcon           = 8'h00;
    if (start_pos) begin
      key_load = 1'b1;
    end else begin
      case (state_q)
        KEXP: begin
          if (kexp_ok) begin
            key_fwd_update = 1'b1;
            rcon           = rcon_lut(kcnt_q);
          end
        end
        RND: begin
          if (rnd_ok) begin
            if (rcnt_q == 4'd10) begin
              state_load     = 1'b1;
              key_inv_update = 1'b1;
              rcon           = rcon_lut(rcnt_q);
            end else if (rcnt_q != 4'd0) begin
              state_update   = 1'b1;
              key_inv_update = 1'b1;
              rcon           = rcon_lut(rcnt_q);
            end else begin
              state_update  = 1'b1;
              is_last_round = 1'b1;
            end
          end
        end
        FIN:     done = 1'b1;
        default: done = 1'b0;
      endcase
    end
  end

  assign busy  = kexp_ok | rnd_ok;
  assign valid = valid_q | done;

  // Delayed start pulse.
  // The plaintext-valid flag is held until the next start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pos_1d <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      start_pos_1d <= start_pos;
      if (start_pos) begin
        valid_q <= 1'b0;
      end else if (done) begin
        valid_q <= 1'b1;
      end
    end
  end

endmodule
